// File: rtl/cg_ctrl_pkg.sv
// Shared types and constants for the idle-detect clock-gating controller.
package cg_ctrl_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_IDLE  = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int unsigned CG_STATS_W = 32;

  function automatic logic cg_clock_on(input cg_state_e s);
    return (s != CG_GATED);
  endfunction

endpackage

// File: rtl/cg_ctrl_stats.sv
// Saturating, clearable cycle counter; clear has priority over increment.
module cg_ctrl_stats
  import cg_ctrl_pkg::*;
#(
  parameter int unsigned W = CG_STATS_W
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gate enable controller with wake settle before grant.
// Optional gated-cycle statistics built when CG_CTRL_STATS_EN is defined.
module clk_gate_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    ack_o,
  input  logic                  busy_i,
  input  logic                  force_on_i,
  input  logic [CNT_W-1:0]      idle_thresh_i,
  output logic                  cg_en_o,
  output logic [1:0]            state_o
`ifdef CG_CTRL_STATS_EN
  ,
  output logic [CG_STATS_W-1:0] gated_cycles_o,
  input  logic                  stats_clr_i
`endif
);

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cg_en_q;
  logic             act;
  logic [CNT_W-1:0] thresh_eff;
  logic             grant_ok;

  assign act        = (|req_i) | busy_i | force_on_i;
  assign thresh_eff = (idle_thresh_i == '0) ? CNT_W'(1) : idle_thresh_i;

  // Shared counter: idle cycles in IDLE, settle cycles in WAKE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_RUN: begin
        if (!act) begin
          state_d = CG_IDLE;
          cnt_d   = CNT_W'(1);
        end
      end
      CG_IDLE: begin
        if (act) begin
          state_d = CG_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= thresh_eff) begin
          state_d = CG_GATED;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CG_GATED: begin
        if (act) begin
          state_d = CG_WAKE;
          cnt_d   = '0;
        end
      end
      CG_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = CG_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CG_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= CG_RUN;
      cnt_q   <= '0;
      cg_en_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cg_en_q <= cg_clock_on(state_d);
    end
  end

  assign grant_ok = rst_b && ((state_q == CG_RUN) || (state_q == CG_IDLE));
  assign ack_o    = req_i & {NUM_REQ{grant_ok}};
  assign cg_en_o  = cg_en_q;
  assign state_o  = state_q;

`ifdef CG_CTRL_STATS_EN
  cg_ctrl_stats #(
    .W (CG_STATS_W)
  ) u_stats (
    .clk   (clk),
    .rst_b (rst_b),
    .clr_i (stats_clr_i),
    .inc_i (state_q == CG_GATED),
    .cnt_o (gated_cycles_o)
  );
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (default parameters, WAKE_CYC=2).
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rst_b;
  logic [3:0] req;
  logic [3:0] ack;
  logic       busy;
  logic       force_on;
  logic [7:0] thresh;
  logic       cg_en;
  logic [1:0] state;
`ifdef CG_CTRL_STATS_EN
  logic [31:0] gated_cycles;
  logic        stats_clr;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [1:0] S_RUN = 2'd0, S_IDLE = 2'd1, S_GATED = 2'd2, S_WAKE = 2'd3;

  clk_gate_ctrl #(
    .NUM_REQ  (4),
    .CNT_W    (8),
    .WAKE_CYC (2)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .req_i          (req),
    .ack_o          (ack),
    .busy_i         (busy),
    .force_on_i     (force_on),
    .idle_thresh_i  (thresh),
    .cg_en_o        (cg_en),
    .state_o        (state)
`ifdef CG_CTRL_STATS_EN
    ,
    .gated_cycles_o (gated_cycles),
    .stats_clr_i    (stats_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] st, input logic en, input logic [3:0] ak);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".cg_en"}, 32'(cg_en), 32'(en));
    check({tag, ".ack"},   32'(ack),   32'(ak));
  endtask

  initial begin
    rst_b = 1'b0; req = 4'hF; busy = 1'b0; force_on = 1'b0; thresh = 8'd4;
`ifdef CG_CTRL_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    check("ack_in_reset_comb", 32'(ack), 32'h0);
    step();
    chk("reset", S_RUN, 1'b1, 4'h0);
`ifdef CG_CTRL_STATS_EN
    check("stats_reset", gated_cycles, 32'd0);
`endif
    req = 4'h0;
    step();                       // edge 0, reset still sampled
    chk("edge0", S_RUN, 1'b1, 4'h0);
    rst_b = 1'b1;

    // Idle gating with thresh=4: IDLE at edge 1, GATED at edge 5
    step(); chk("idle_e1", S_IDLE, 1'b1, 4'h0);
    step(); chk("idle_e2", S_IDLE, 1'b1, 4'h0);
    step(); chk("idle_e3", S_IDLE, 1'b1, 4'h0);
    step(); chk("idle_e4", S_IDLE, 1'b1, 4'h0);
    step(); chk("gated_e5", S_GATED, 1'b0, 4'h0);

    // Wake on req[2]: grant three edges later
    req = 4'b0100; #1;
    check("ack_gated_comb", 32'(ack), 32'h0);
    step(); chk("wake_1", S_WAKE, 1'b1, 4'h0);
    step(); chk("wake_2", S_WAKE, 1'b1, 4'h0);
    step(); chk("wake_run", S_RUN, 1'b1, 4'b0100);
    req = 4'b0110; #1;
    check("ack_follow_comb", 32'(ack), 32'h6);

    // busy pulse at IDLE cnt=3 restarts the count
    req = 4'h0;
    step(); step(); step();
    chk("idle_cnt3", S_IDLE, 1'b1, 4'h0);
    busy = 1'b1;
    step(); chk("busy_run", S_RUN, 1'b1, 4'h0);
    busy = 1'b0;
    step(); step(); step(); step();
    chk("busy_idle4", S_IDLE, 1'b1, 4'h0);
    step(); chk("busy_gated", S_GATED, 1'b0, 4'h0);

    // thresh=0 behaves as 1
    req = 4'b0001;
    step(); step(); step();
    chk("wake2_run", S_RUN, 1'b1, 4'b0001);
    req = 4'h0; thresh = 8'd0;
    step(); chk("t0_idle", S_IDLE, 1'b1, 4'h0);
    step(); chk("t0_gated", S_GATED, 1'b0, 4'h0);

    // req dropped during WAKE: wake completes, no ack, re-gates
    req = 4'b1000;
    step(); chk("drop_wake1", S_WAKE, 1'b1, 4'h0);
    req = 4'h0;
    step(); chk("drop_wake2", S_WAKE, 1'b1, 4'h0);
    step(); chk("drop_run", S_RUN, 1'b1, 4'h0);
    step(); chk("drop_idle", S_IDLE, 1'b1, 4'h0);
    step(); chk("drop_gated", S_GATED, 1'b0, 4'h0);

    // force_on wakes and holds the clock on
    force_on = 1'b1;
    step(); step(); step();
    chk("force_run", S_RUN, 1'b1, 4'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("force_hold_state", 32'(state), 32'(S_RUN));
      check("force_hold_en", 32'(cg_en), 32'd1);
    end
    force_on = 1'b0;
    step(); chk("force_off_idle", S_IDLE, 1'b1, 4'h0);
    step(); chk("force_off_gated", S_GATED, 1'b0, 4'h0);

    // act coincident with threshold reached: act wins
    thresh = 8'd2; req = 4'b0010;
    step(); step(); step();
    req = 4'h0;
    step(); step();
    chk("tie_idle_cnt2", S_IDLE, 1'b1, 4'h0);
    busy = 1'b1;
    step(); chk("tie_run", S_RUN, 1'b1, 4'h0);
    busy = 1'b0;

    // threshold lowered mid-count gates on the next edge
    thresh = 8'd8;
    step(); step(); step();
    chk("lower_idle_cnt3", S_IDLE, 1'b1, 4'h0);
    thresh = 8'd2;
    step(); chk("lower_gated", S_GATED, 1'b0, 4'h0);

    // reset during GATED, then during WAKE
    rst_b = 1'b0;
    step(); chk("rst_from_gated", S_RUN, 1'b1, 4'h0);
    rst_b = 1'b1; thresh = 8'd1;
    step(); step();
    chk("pre_wake_gated", S_GATED, 1'b0, 4'h0);
    req = 4'b0001;
    step(); chk("pre_rst_wake", S_WAKE, 1'b1, 4'h0);
    rst_b = 1'b0;
    step(); chk("rst_from_wake", S_RUN, 1'b1, 4'h0);
    rst_b = 1'b1; req = 4'h0;

`ifdef CG_CTRL_STATS_EN
    step(); step();
    check("stats_enter", gated_cycles, 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("stats_ten", gated_cycles, 32'd10);
    stats_clr = 1'b1;
    step(); check("stats_clr", gated_cycles, 32'd0);
    stats_clr = 1'b0;
    step(); check("stats_recount", gated_cycles, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
